// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Optional feature macro: IMM_ENC_CHECK_EN (immediate range/alignment checking).
package imm_encoder_pkg;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 7;
  localparam int REG_W  = 5;
  localparam int F3_W   = 3;
  localparam int F7_W   = 7;

  // Immediate format selector; encodings above IMM_J_TYPE all behave as R-type.
  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_S_TYPE = 3'd1,
    IMM_B_TYPE = 3'd2,
    IMM_U_TYPE = 3'd3,
    IMM_J_TYPE = 3'd4,
    IMM_R_TYPE = 3'd5
  } imm_sel_t;

  typedef logic [DATA_W-1:0] imm_t;
  typedef logic [DATA_W-1:0] data_t;

  // One encode request as captured by the first pipeline stage.
  typedef struct packed {
    imm_sel_t           sel;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [F3_W-1:0]    funct3;
    logic [F7_W-1:0]    funct7;
    imm_t               imm;
  } enc_req_t;

  // True when bits [31:lsb] of v are all equal, i.e. v is representable as a
  // sign-extended value whose sign bit sits at position lsb.
  function automatic logic fits_signed(input imm_t v, input int unsigned lsb);
    imm_t w_shifted;
    w_shifted = imm_t'($signed(v) >>> lsb);
    return (w_shifted == '0) || (w_shifted == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate placement for each RV32I format plus the range flag.
// Optional feature macro: IMM_ENC_CHECK_EN (without it the range flag is 0).
module imm_pack
  import imm_encoder_pkg::*;
(
  input  imm_sel_t i_sel,
  input  imm_t     i_imm,
  output data_t    o_imm_bits,
  output logic     o_range_err
);

  // Scatter immediate bits into their instruction-word positions; other bits stay 0.
  always_comb begin
    o_imm_bits = '0;
    case (i_sel)
      IMM_I_TYPE: o_imm_bits[31:20] = i_imm[11:0];
      IMM_S_TYPE: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
      end
      IMM_B_TYPE: begin
        o_imm_bits[31]    = i_imm[12];
        o_imm_bits[30:25] = i_imm[10:5];
        o_imm_bits[11:8]  = i_imm[4:1];
        o_imm_bits[7]     = i_imm[11];
      end
      IMM_U_TYPE: o_imm_bits[31:12] = i_imm[31:12];
      IMM_J_TYPE: begin
        o_imm_bits[31]    = i_imm[20];
        o_imm_bits[30:21] = i_imm[10:1];
        o_imm_bits[20]    = i_imm[11];
        o_imm_bits[19:12] = i_imm[19:12];
      end
      default: o_imm_bits = '0;
    endcase
  end

`ifdef IMM_ENC_CHECK_EN
  // Flag immediates that do not fit the format or are misaligned branch/jump offsets.
  always_comb begin
    o_range_err = 1'b0;
    case (i_sel)
      IMM_I_TYPE, IMM_S_TYPE: o_range_err = !fits_signed(i_imm, 11);
      IMM_B_TYPE:             o_range_err = !fits_signed(i_imm, 12) || i_imm[0];
      IMM_U_TYPE:             o_range_err = (i_imm[11:0] != 12'd0);
      IMM_J_TYPE:             o_range_err = !fits_signed(i_imm, 20) || i_imm[0];
      default:                o_range_err = 1'b0;
    endcase
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline packing decoded
// fields and an immediate into an instruction word, with saturating statistics.
// Optional feature macro: IMM_ENC_CHECK_EN (err_o / err_cnt_o active when defined).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  imm_sel_t         imm_sel_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [F3_W-1:0]  funct3_i,
  input  logic [F7_W-1:0]  funct7_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  enc_req_t   w_req;
  enc_req_t   r_s1_req;
  logic       r_s1_valid;
  logic       r_s2_valid;
  data_t      r_s2_instr;
  logic       r_s2_err;
  logic       w_s2_load;
  logic       w_accept;
  logic       w_out_fire;
  data_t      w_imm_bits;
  data_t      w_word;
  logic       w_range_err;
  logic [CNT_W-1:0] r_enc_cnt;

  // S2 can take a word when empty or draining; S1 drains into it under the same condition.
  assign w_s2_load  = !r_s2_valid || out_ready_i;
  assign in_ready_o = !r_s1_valid || w_s2_load;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_out_fire = r_s2_valid && out_ready_i;

  // Gather the request fields into one record.
  always_comb begin
    w_req        = '0;
    w_req.sel    = imm_sel_i;
    w_req.opcode = opcode_i;
    w_req.rd     = rd_i;
    w_req.rs1    = rs1_i;
    w_req.rs2    = rs2_i;
    w_req.funct3 = funct3_i;
    w_req.funct7 = funct7_i;
    w_req.imm    = imm_t'(imm_i);
  end

  // Stage 1: capture an accepted request, otherwise empty out when S2 takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_req   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_req   <= w_req;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  imm_pack u_imm_pack (
    .i_sel       (r_s1_req.sel),
    .i_imm       (r_s1_req.imm),
    .o_imm_bits  (w_imm_bits),
    .o_range_err (w_range_err)
  );

  // Place the non-immediate fields that each format carries, then merge the immediate.
  always_comb begin
    w_word      = '0;
    w_word[6:0] = r_s1_req.opcode;
    case (r_s1_req.sel)
      IMM_I_TYPE: begin
        w_word[11:7]  = r_s1_req.rd;
        w_word[14:12] = r_s1_req.funct3;
        w_word[19:15] = r_s1_req.rs1;
      end
      IMM_S_TYPE, IMM_B_TYPE: begin
        w_word[14:12] = r_s1_req.funct3;
        w_word[19:15] = r_s1_req.rs1;
        w_word[24:20] = r_s1_req.rs2;
      end
      IMM_U_TYPE, IMM_J_TYPE: w_word[11:7] = r_s1_req.rd;
      default: begin
        w_word[11:7]  = r_s1_req.rd;
        w_word[14:12] = r_s1_req.funct3;
        w_word[19:15] = r_s1_req.rs1;
        w_word[24:20] = r_s1_req.rs2;
        w_word[31:25] = r_s1_req.funct7;
      end
    endcase
    w_word = w_word | w_imm_bits;
  end

  // Stage 2: load when empty or draining; the word is held stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_word;
        r_s2_err   <= w_range_err;
      end
    end
  end

  // Count delivered words, sticking at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_cnt <= '0;
    end else if (w_out_fire && (r_enc_cnt != '1)) begin
      r_enc_cnt <= r_enc_cnt + 1'b1;
    end
  end

`ifdef IMM_ENC_CHECK_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Count delivered words flagged as out of range, sticking at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_fire && r_s2_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  assign out_valid_o = r_s2_valid;
  assign instr_o     = XLEN'(r_s2_instr);
  assign err_o       = r_s2_err;
  assign enc_cnt_o   = r_enc_cnt;

endmodule
